// File: rtl/memory_stage.sv
// Memory stage: turns load/store requests into a registered memory
// handshake and freezes the upstream pipe until the access completes.
module memory_stage #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] st_val_in,
  input  logic [3:0]  dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_st_val;
  logic        r_wb_en;
  logic        r_mem_r_en;
  logic [31:0] r_alu;
  logic [3:0]  r_dest;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic        w_access;
  logic [31:0] w_byte_off;
  logic [31:0] w_word_addr;

  assign w_idle   = (r_state == IDLE);
  assign w_access = w_idle & (mem_r_en_in | mem_w_en_in);

  // Low address bits are dropped: a misaligned access hits its word.
  assign w_byte_off  = {alu_result_in[31:2], 2'b00} - BASE_ADDR;
  assign w_word_addr = w_byte_off >> 2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_st_val   <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_alu      <= '0;
      r_dest     <= '0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_access) begin
            r_wb_en    <= wb_en_in;
            // A store wins when both enables are set.
            r_mem_r_en <= mem_r_en_in & ~mem_w_en_in;
            r_alu      <= alu_result_in;
            r_dest     <= dest_in;
            r_st_val   <= st_val_in;
            r_rdata    <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= mem_w_en_in;
            r_mem_addr <= w_word_addr;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            r_rdata   <= r_mem_r_en ? mem_rdata : '0;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_st_val;

  assign stall = w_access | (r_state == BUSY);

  assign wb_en_out      = w_idle ? wb_en_in : r_wb_en;
  assign mem_r_en_out   = w_idle ? mem_r_en_in : r_mem_r_en;
  assign alu_result_out = w_idle ? alu_result_in : r_alu;
  assign dest_out       = w_idle ? dest_in : r_dest;
  assign mem_data_out   = (r_state == DONE) ? r_rdata : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, loads, stores,
// store priority, address mapping, reset during an access.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] st_val_in;
  logic [3:0]  dest_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic [3:0]  dest_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          stalls;
    logic        req_before;
    bit          stable;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        d_wb;
    logic        d_ren;
    logic        d_req;
    logic [31:0] d_alu;
    logic [31:0] d_data;
    logic [3:0]  d_dest;
  } obs_t;

  always #5 clk = ~clk;

  memory_stage #(.BASE_ADDR(32'd1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .alu_result_in  (alu_result_in),
    .st_val_in      (st_val_in),
    .dest_in        (dest_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .wb_en_out      (wb_en_out),
    .mem_r_en_out   (mem_r_en_out),
    .alu_result_out (alu_result_out),
    .mem_data_out   (mem_data_out),
    .dest_out       (dest_out)
  );

  task automatic set_nop();
    wb_en_in      = 1'b0;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = 1'b0;
    alu_result_in = '0;
    st_val_in     = '0;
    dest_in       = '0;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
  endtask

  // Presents one access in an IDLE cycle, answers with mem_ready in
  // the delay-th BUSY cycle and records what was observed, incl. DONE.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic        wb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [3:0]  dest,
    input  int          delay,
    output obs_t        o
  );
    bit fin;
    fin = 1'b0;
    o = '{default: 0};
    o.stable = 1'b1;
    @(negedge clk);
    wb_en_in      = wb;
    mem_r_en_in   = rd;
    mem_w_en_in   = wr;
    alu_result_in = addr;
    st_val_in     = wdata;
    dest_in       = dest;
    mem_rdata     = rdata;
    mem_ready     = 1'b0;
    #1;
    o.req_before = mem_req;
    o.stalls = stall ? 1 : 0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge clk);
      mem_ready = (k == delay);
      #1;
      if (!stall) begin
        fin      = 1'b1;
        o.d_wb   = wb_en_out;
        o.d_ren  = mem_r_en_out;
        o.d_req  = mem_req;
        o.d_alu  = alu_result_out;
        o.d_data = mem_data_out;
        o.d_dest = dest_out;
      end else begin
        o.stalls++;
        if (mem_req !== 1'b1) o.stable = 1'b0;
        if (k == 1) begin
          o.we    = mem_we;
          o.addr  = mem_addr;
          o.wdata = mem_wdata;
        end else if (mem_we !== o.we || mem_addr !== o.addr ||
                     mem_wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
      end
    end
    if (!fin) o.stalls = -1;
    set_nop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, stall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000",
               {mem_req, mem_we, stall});
    end
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_addr_data got=%h/%h exp=0/0",
               mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu_result_in = 32'h77;
    dest_in = 4'd6;
    #1;
    checks++;
    if (alu_result_out !== 32'h77 || dest_out !== 4'd6 ||
        stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_pass got=%h/%0d/%b exp=77/6/0",
               alu_result_out, dest_out, stall);
    end
    set_nop();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    wb_en_in = 1'b1;
    alu_result_in = 32'h55;
    dest_in = 4'd3;
    #1;
    checks++;
    if (alu_result_out !== 32'h55 || dest_out !== 4'd3 ||
        wb_en_out !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL pass_out got=%h/%0d/%b/%b exp=55/3/1/0",
               alu_result_out, dest_out, wb_en_out, stall);
    end
    checks++;
    if (mem_data_out !== 32'd0 || mem_r_en_out !== 1'b0) begin
      failures++;
      $display("FAIL pass_data got=%h/%b exp=0/0",
               mem_data_out, mem_r_en_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL pass_req got=%b exp=0", mem_req);
    end
    set_nop();
  endtask

  task automatic test_load();
    obs_t o;
    run_access(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0,
               32'hDEADBEEF, 4'd5, 1, o);
    checks++;
    if (o.stalls !== 2) begin
      failures++;
      $display("FAIL load_stalls got=%0d exp=2", o.stalls);
    end
    checks++;
    if (o.addr !== 32'd2 || o.we !== 1'b0 || o.req_before !== 1'b0) begin
      failures++;
      $display("FAIL load_req got=%h/%b/%b exp=2/0/0",
               o.addr, o.we, o.req_before);
    end
    checks++;
    if (o.d_data !== 32'hDEADBEEF || o.d_ren !== 1'b1) begin
      failures++;
      $display("FAIL load_done got=%h/%b exp=deadbeef/1",
               o.d_data, o.d_ren);
    end
    checks++;
    if (o.d_alu !== 32'd1032 || o.d_dest !== 4'd5 ||
        o.d_wb !== 1'b1 || o.d_req !== 1'b0) begin
      failures++;
      $display("FAIL load_latch got=%0d/%0d/%b/%b exp=1032/5/1/0",
               o.d_alu, o.d_dest, o.d_wb, o.d_req);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h12345678,
               32'hAAAA5555, 4'd0, 5, o);
    checks++;
    if (o.stalls !== 6) begin
      failures++;
      $display("FAIL store_stalls got=%0d exp=6", o.stalls);
    end
    checks++;
    if (o.we !== 1'b1 || o.addr !== 32'd0 ||
        o.wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL store_req got=%b/%h/%h exp=1/0/12345678",
               o.we, o.addr, o.wdata);
    end
    checks++;
    if (o.stable !== 1'b1) begin
      failures++;
      $display("FAIL store_stable got=%b exp=1", o.stable);
    end
    checks++;
    if (o.d_data !== 32'd0 || o.d_ren !== 1'b0) begin
      failures++;
      $display("FAIL store_done got=%h/%b exp=0/0", o.d_data, o.d_ren);
    end
  endtask

  task automatic test_priority();
    obs_t o;
    run_access(1'b1, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D,
               32'h11111111, 4'd7, 2, o);
    checks++;
    if (o.we !== 1'b1 || o.addr !== 32'd4 || o.stalls !== 3) begin
      failures++;
      $display("FAIL prio_req got=%b/%h/%0d exp=1/4/3",
               o.we, o.addr, o.stalls);
    end
    checks++;
    if (o.d_ren !== 1'b0 || o.d_data !== 32'd0) begin
      failures++;
      $display("FAIL prio_done got=%b/%h exp=0/0", o.d_ren, o.d_data);
    end
  endtask

  task automatic test_addr_map();
    obs_t o;
    run_access(1'b1, 1'b0, 1'b1, 32'd1035, 32'h0,
               32'h0BADF00D, 4'd2, 1, o);
    checks++;
    if (o.addr !== 32'd2 || o.d_data !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL misalign got=%h/%h exp=2/0badf00d",
               o.addr, o.d_data);
    end
    run_access(1'b1, 1'b0, 1'b1, 32'd0, 32'h0,
               32'h0, 4'd2, 1, o);
    checks++;
    if (o.addr !== 32'h3FFFFF00) begin
      failures++;
      $display("FAIL underflow got=%h exp=3fffff00", o.addr);
    end
  endtask

  task automatic test_ready_idle();
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h99;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_data_out !== 32'd0) begin
      failures++;
      $display("FAIL rdy_idle got=%b/%h exp=0/0", stall, mem_data_out);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 ||
        mem_data_out !== 32'd0) begin
      failures++;
      $display("FAIL rdy_idle_after got=%b/%b/%h exp=0/0/0",
               mem_req, stall, mem_data_out);
    end
    set_nop();
  endtask

  task automatic test_back_to_back();
    obs_t a;
    obs_t b;
    run_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0,
               32'h1111AAAA, 4'd1, 1, a);
    run_access(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0,
               32'h2222BBBB, 4'd2, 2, b);
    checks++;
    if (a.d_data !== 32'h1111AAAA || a.d_dest !== 4'd1 ||
        a.addr !== 32'd1) begin
      failures++;
      $display("FAIL b2b_first got=%h/%0d/%h exp=1111aaaa/1/1",
               a.d_data, a.d_dest, a.addr);
    end
    checks++;
    if (b.d_data !== 32'h2222BBBB || b.d_dest !== 4'd2 ||
        b.addr !== 32'd3) begin
      failures++;
      $display("FAIL b2b_second got=%h/%0d/%h exp=2222bbbb/2/3",
               b.d_data, b.d_dest, b.addr);
    end
    checks++;
    if (b.req_before !== 1'b0 || a.d_req !== 1'b0 ||
        b.stalls !== 3) begin
      failures++;
      $display("FAIL b2b_gap got=%b/%b/%0d exp=0/0/3",
               b.req_before, a.d_req, b.stalls);
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    mem_r_en_in = 1'b1;
    wb_en_in = 1'b1;
    alu_result_in = 32'd1048;
    dest_in = 4'd9;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("FAIL rstb_busy got=%b/%b exp=1/1", mem_req, stall);
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rst_n = 1'b1;
    set_nop();
    alu_result_in = 32'h33;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_data_out !== 32'd0 ||
        stall !== 1'b0) begin
      failures++;
      $display("FAIL rstb_after got=%b/%h/%b exp=0/0/0",
               mem_req, mem_data_out, stall);
    end
    checks++;
    if (alu_result_out !== 32'h33 || mem_addr !== 32'd0 ||
        mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rstb_idle got=%h/%h/%b exp=33/0/0",
               alu_result_out, mem_addr, mem_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_data_out !== 32'd0) begin
      failures++;
      $display("FAIL rstb_next got=%b/%h exp=0/0",
               mem_req, mem_data_out);
    end
    set_nop();
  endtask

  initial begin
    set_nop();
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_priority();
    test_addr_map();
    test_ready_idle();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024: byte address that maps to data-memory word 0.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port wb_en_in, input, 1: writeback enable from the EXE/MEM register.
REQ-005 SHALL have port mem_r_en_in, input, 1: load request.
REQ-006 SHALL have port mem_w_en_in, input, 1: store request.
REQ-007 SHALL have port alu_result_in, input, 32: effective byte address, or the ALU value for non-memory operations.
REQ-008 SHALL have port st_val_in, input, 32: store data.
REQ-009 SHALL have port dest_in, input, 4: destination register.
REQ-010 SHALL have port mem_req, output, 1: memory request, registered.
REQ-011 SHALL have port mem_we, output, 1: memory write strobe, registered.
REQ-012 SHALL have port mem_addr, output, 32: memory word address, registered.
REQ-013 SHALL have port mem_wdata, output, 32: memory write data, registered.
REQ-014 SHALL have port mem_rdata, input, 32: memory read data, valid while mem_ready=1.
REQ-015 SHALL have port mem_ready, input, 1: memory completion, single-cycle pulse.
REQ-016 SHALL have port stall, output, 1: freeze for upstream pipe registers and the PC.
REQ-017 SHALL have ports wb_en_out (1), mem_r_en_out (1), alu_result_out (32), mem_data_out (32) and dest_out (4), all outputs to the MEM/WB register.

Function
REQ-018 SHALL implement an FSM with states IDLE, BUSY and DONE; reset state is IDLE.
REQ-019 SHALL treat a cycle as an access when the FSM is in IDLE and mem_r_en_in|mem_w_en_in=1.
REQ-020 SHALL, in IDLE with no access, drive stall=0 and pass wb_en_in, mem_r_en_in, alu_result_in and dest_in combinationally to the outputs, with mem_data_out=0 (zero added latency).
REQ-021 SHALL, on an access in IDLE, drive stall=1 and latch wb_en, mem_r_en, alu_result, dest and st_val. On the same edge it SHALL load mem_req<=1, mem_we<=mem_w_en_in, mem_addr<=(alu_result_in-BASE_ADDR)>>2 (logical shift, 32-bit wrap on underflow) and mem_wdata<=st_val_in, and move to BUSY.
REQ-022 SHALL give a store priority when mem_r_en_in and mem_w_en_in are both 1: mem_we=1, and mem_r_en_out=0 in DONE.
REQ-023 SHALL ignore alu_result_in[1:0] for addressing; a misaligned address accesses the containing word.
REQ-024 SHALL, in BUSY, hold mem_req, mem_we, mem_addr and mem_wdata stable and drive stall=1.
REQ-025 SHALL, in BUSY with mem_ready=1, capture mem_rdata (loads only, otherwise 0), clear mem_req on that edge, and move to DONE; stall stays 1 in that cycle.
REQ-026 SHALL, in DONE, drive stall=0 and present the latched wb_en, mem_r_en, alu_result and dest plus the captured read data on the outputs; the next state SHALL be IDLE unconditionally.
REQ-027 SHALL add a minimum of 2 stall cycles per access: the access cycle plus at least one BUSY cycle.
REQ-028 SHALL ignore mem_ready while in IDLE or DONE.
REQ-029 SHALL never assert mem_req for two back-to-back transactions without passing through DONE and IDLE.
REQ-030 SHALL NOT time out: BUSY persists for as long as mem_ready stays 0.

Reset
REQ-031 SHALL, with rst_n=0 at a rising edge, force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, and clear all latches and captured data to 0.
REQ-032 SHALL give reset priority over all events, including an active access or a coincident mem_ready; the in-flight transaction is abandoned and its data discarded.
REQ-033 SHALL drive stall=0 and all outputs pass-through from the first cycle after reset, provided no access is presented.

Verification
REQ-034 SHALL be verified with: non-memory op alu_result_in=0x55, dest_in=3, wb_en_in=1 -> same cycle alu_result_out=0x55, dest_out=3, stall=0, and mem_req remains 0.
REQ-035 SHALL be verified with: load at alu_result_in=1032, mem_ready returned one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=2, stall high for exactly 2 cycles, DONE shows mem_data_out=0xDEADBEEF and mem_r_en_out=1.
REQ-036 SHALL be verified with: store of st_val_in=0x12345678 to 1024 with mem_ready delayed 5 cycles -> mem_we=1, mem_addr=0, mem_wdata=0x12345678 stable throughout, stall high for 6 cycles.
REQ-037 SHALL be verified with: mem_r_en_in and mem_w_en_in both 1 -> mem_we=1 and mem_r_en_out=0 in DONE.
REQ-038 SHALL be verified with: rst_n=0 asserted in BUSY coincident with mem_ready=1 -> next cycle state IDLE, mem_req=0 and mem_data_out=0.
REQ-039 SHALL be verified with: two loads presented back-to-back -> two separate mem_req pulses separated by DONE and IDLE, with each read value delivered to its own DONE cycle.
